picosoc_dmem_arb: RTL and testbench

PICOSOC_DMEM_ARB -- requirements
Module: picosoc_dmem_arb

---
 rtl/picosoc_dmem_arb.sv | 88 ++++++++
 tb/tb_picosoc_dmem_arb.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/picosoc_dmem_arb.sv
// picosoc_dmem_arb: N-port arbiter in front of a single data memory,
// with fixed-latency pipelined ready/rdata/err return.
module picosoc_dmem_arb #(
  parameter int N_PORTS = 2,
  parameter int DMEM_SIZE = 16384,
  parameter int DMEM_DELAY = 1,
  parameter int ARB_MODE = 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [N_PORTS-1:0]     p_valid,
  input  logic [32*N_PORTS-1:0]  p_addr,
  input  logic [4*N_PORTS-1:0]   p_wstrb,
  input  logic [32*N_PORTS-1:0]  p_wdata,
  output logic [N_PORTS-1:0]     p_ready,
  output logic [31:0]            p_rdata,
  output logic [N_PORTS-1:0]     p_err,
  output logic [2:0]             gnt_id,
  output logic                   gnt_vld
);
  localparam int AW = $clog2(DMEM_SIZE);
  localparam int L = DMEM_DELAY - 1;
  logic [31:0] mem [DMEM_SIZE];
  logic [31:0] rq [DMEM_DELAY];
  logic [2:0] sid [DMEM_DELAY];
  logic [DMEM_DELAY-1:0] sv, se, sr;
  logic [N_PORTS-1:0] infl, elig;
  logic [2:0] ptr;
  logic [31:0] g_addr, g_wdata;
  logic [3:0] g_wstrb;
  logic in_rng;
  assign elig = p_valid & ~infl & ~p_ready;
  // Scan from the back so the first port in search order is the last one to win.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id = '0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      automatic int j = (ARB_MODE != 0) ? (int'(ptr) + 1 + i) % N_PORTS : i;
      if (resetn && elig[j]) begin
        gnt_vld = 1'b1;
        gnt_id = 3'(j);
      end
    end
  end
  assign g_addr = p_addr[32*gnt_id +: 32];
  assign g_wstrb = p_wstrb[4*gnt_id +: 4];
  assign g_wdata = p_wdata[32*gnt_id +: 32];
  assign in_rng = g_addr < 32'(4 * DMEM_SIZE);
  // Memory and read-data shift chain carry no reset; validity travels in sv.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (gnt_vld && in_rng && g_wstrb[b]) mem[g_addr[AW+1:2]][8*b +: 8] <= g_wdata[8*b +: 8];
    rq[0] <= mem[g_addr[AW+1:2]];
    for (int i = 1; i < DMEM_DELAY; i++) rq[i] <= rq[i-1];
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sv <= '0;
      se <= '0;
      sr <= '0;
      infl <= '0;
      ptr <= 3'(N_PORTS - 1);
      for (int i = 0; i < DMEM_DELAY; i++) sid[i] <= '0;
    end else begin
      for (int i = DMEM_DELAY - 1; i > 0; i--) begin
        sv[i] <= sv[i-1];
        se[i] <= se[i-1];
        sr[i] <= sr[i-1];
        sid[i] <= sid[i-1];
      end
      sv[0] <= gnt_vld;
      se[0] <= !in_rng;
      sr[0] <= in_rng && g_wstrb == 4'h0;
      sid[0] <= gnt_id;
      infl <= (infl & ~p_ready) | ({{(N_PORTS-1){1'b0}}, gnt_vld} << gnt_id);
      if (gnt_vld) ptr <= gnt_id;
    end
  end
  always_comb begin
    p_ready = '0;
    p_err = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      p_ready[k] = sv[L] && sid[L] == 3'(k);
      p_err[k] = sv[L] && sid[L] == 3'(k) && se[L];
    end
  end
  assign p_rdata = (sv[L] && sr[L]) ? rq[L] : '0;
endmodule

// File: tb/tb_picosoc_dmem_arb.sv
// tb_picosoc_dmem_arb: vector table, directed corner sequences and a random
// run against a transaction-level model, on a round-robin and a fixed-priority instance.
module tb_picosoc_dmem_arb;
  localparam int NP = 3;
  typedef struct {
    int u; int p; logic [31:0] a; logic [3:0] s; logic [31:0] d;
    logic [31:0] er; logic ee; int el;
  } vec_t;
  typedef struct { int due; int p; logic [31:0] dat; logic e; } cmp_t;
  logic clk = 0, resetn = 0;
  logic [NP-1:0] valid [2], ready [2], err [2];
  logic [32*NP-1:0] addr [2], wdata [2];
  logic [4*NP-1:0] strb [2];
  logic [31:0] rdata [2];
  logic [2:0] gid [2];
  logic gv [2];
  logic [31:0] mm [int];
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  picosoc_dmem_arb #(.N_PORTS(NP), .DMEM_SIZE(16384), .DMEM_DELAY(1), .ARB_MODE(1)) dut_rr (
    .clk(clk), .resetn(resetn), .p_valid(valid[0]), .p_addr(addr[0]), .p_wstrb(strb[0]),
    .p_wdata(wdata[0]), .p_ready(ready[0]), .p_rdata(rdata[0]), .p_err(err[0]),
    .gnt_id(gid[0]), .gnt_vld(gv[0]));
  picosoc_dmem_arb #(.N_PORTS(NP), .DMEM_SIZE(16384), .DMEM_DELAY(3), .ARB_MODE(0)) dut_fp (
    .clk(clk), .resetn(resetn), .p_valid(valid[1]), .p_addr(addr[1]), .p_wstrb(strb[1]),
    .p_wdata(wdata[1]), .p_ready(ready[1]), .p_rdata(rdata[1]), .p_err(err[1]),
    .gnt_id(gid[1]), .gnt_vld(gv[1]));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    resetn = 0;
    @(posedge clk); #1;
    resetn = 1;
  endtask

  task automatic xact(input int u, input int p, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, output logic [31:0] rd, output logic e,
                      output int lat, output logic gok);
    addr[u][32*p +: 32] = a;
    strb[u][4*p +: 4] = s;
    wdata[u][32*p +: 32] = d;
    valid[u][p] = 1'b1;
    rd = '0; e = 0; lat = -1; gok = 0;
    for (int c = 0; c < 12 && lat < 0; c++) begin
      @(negedge clk);
      if (c == 0) gok = gv[u] && gid[u] == 3'(p);
      if (ready[u][p]) begin
        rd = rdata[u];
        e = err[u][p];
        lat = c;
      end
      @(posedge clk); #1;
    end
    valid[u][p] = 1'b0;
  endtask

  task automatic gseq(input int u, input int e[8]);
    do_reset();
    for (int p = 0; p < NP; p++) begin
      addr[u][32*p +: 32] = 32'h140 + 32'(4 * p);
      strb[u][4*p +: 4] = 4'h0;
    end
    valid[u] = '1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (e[c] < 0) check($sformatf("gseq%0d_c%0d", u, c), 32'(gv[u]), 32'd0);
      else check($sformatf("gseq%0d_c%0d", u, c), {28'd0, gv[u], gid[u]}, {28'd0, 1'b1, 3'(e[c])});
      @(posedge clk); #1;
    end
    valid[u] = '0;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic rand_run(input int u, input int d, input int mode, input int ncyc);
    cmp_t q[$];
    cmp_t x;
    logic [NP-1:0] act, infl, elig, er, ee;
    logic [31:0] ra [NP], rw [NP], ed, rd, t;
    logic [3:0] rs [NP];
    logic e, gok, inr;
    int last, w, lat, sel, k;
    for (int i = 0; i < 8; i++) begin
      t = $urandom;
      xact(u, 0, 32'h100 + 32'(4 * i), 4'hF, t, rd, e, lat, gok);
      mm[u * 65536 + 64 + i] = t;
    end
    do_reset();
    act = '0; infl = '0; last = NP - 1;
    for (int c = 0; c < ncyc; c++) begin
      for (int p = 0; p < NP; p++)
        if (!act[p] && $urandom_range(1, 0) == 1) begin
          act[p] = 1'b1;
          sel = $urandom_range(7, 0);
          ra[p] = sel == 0 ? 32'h0001_0000 + 32'(4 * $urandom_range(7, 0)) :
                  sel == 1 ? 32'h8000_0100 : 32'h100 + 32'(4 * $urandom_range(7, 0));
          rs[p] = $urandom_range(1, 0) == 1 ? 4'($urandom_range(15, 0)) : 4'h0;
          rw[p] = $urandom;
          addr[u][32*p +: 32] = ra[p];
          strb[u][4*p +: 4] = rs[p];
          wdata[u][32*p +: 32] = rw[p];
        end
      valid[u] = act;
      @(negedge clk);
      er = '0; ee = '0; ed = '0;
      if (q.size() > 0 && q[0].due == c) begin
        x = q.pop_front();
        er[x.p] = 1'b1;
        ee[x.p] = x.e;
        ed = x.dat;
      end
      elig = act & ~infl & ~er;
      w = -1;
      for (int i = 0; i < NP && w < 0; i++) begin
        k = mode != 0 ? (last + 1 + i) % NP : i;
        if (elig[k]) w = k;
      end
      check("rnd_gvld", 32'(gv[u]), 32'(w >= 0));
      if (w >= 0) check("rnd_gid", 32'(gid[u]), 32'(w));
      check("rnd_ready", 32'(ready[u]), 32'(er));
      check("rnd_err", 32'(err[u]), 32'(ee));
      check("rnd_rdata", rdata[u], ed);
      if (w >= 0) begin
        infl[w] = 1'b1;
        last = w;
        inr = ra[w] < 32'h1_0000;
        k = u * 65536 + int'(ra[w] >> 2);
        x.due = c + d; x.p = w; x.e = !inr; x.dat = '0;
        if (inr && rs[w] == 4'h0) x.dat = mm[k];
        if (inr && rs[w] != 4'h0) begin
          t = mm[k];
          for (int b = 0; b < 4; b++) if (rs[w][b]) t[8*b +: 8] = rw[w][8*b +: 8];
          mm[k] = t;
        end
        q.push_back(x);
      end
      infl = infl & ~er;
      act = act & ~er;
      @(posedge clk); #1;
    end
    valid[u] = '0;
    repeat (d + 3) @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t tbl [$];
    logic [31:0] rd;
    logic e, gok;
    int lat, n;
    for (int u = 0; u < 2; u++) begin
      valid[u] = '1; addr[u] = '0; strb[u] = '0; wdata[u] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check($sformatf("rst_ready%0d", u), 32'(ready[u]), 32'd0);
      check($sformatf("rst_err%0d", u), 32'(err[u]), 32'd0);
      check($sformatf("rst_rdata%0d", u), rdata[u], 32'd0);
      check($sformatf("rst_gvld%0d", u), 32'(gv[u]), 32'd0);
      check($sformatf("rst_gid%0d", u), 32'(gid[u]), 32'd0);
      valid[u] = '0;
    end
    @(posedge clk); #1;
    resetn = 1;
    tbl.push_back('{0, 0, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0, 1});
    tbl.push_back('{0, 0, 32'h10, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0, 1});
    tbl.push_back('{0, 1, 32'h20, 4'hF, 32'h11223344, 32'h0, 1'b0, 1});
    tbl.push_back('{0, 1, 32'h20, 4'h5, 32'hAABBCCDD, 32'h0, 1'b0, 1});
    tbl.push_back('{0, 2, 32'h20, 4'h0, 32'h0, 32'h11BB33DD, 1'b0, 1});
    tbl.push_back('{0, 2, 32'hFFFC, 4'hF, 32'h0BADF00D, 32'h0, 1'b0, 1});
    tbl.push_back('{0, 0, 32'hFFFC, 4'h0, 32'h0, 32'h0BADF00D, 1'b0, 1});
    tbl.push_back('{0, 2, 32'h10000, 4'h0, 32'h0, 32'h0, 1'b1, 1});
    tbl.push_back('{1, 0, 32'h0, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0, 3});
    tbl.push_back('{1, 1, 32'h10000, 4'h0, 32'h0, 32'h0, 1'b1, 3});
    tbl.push_back('{1, 1, 32'h10000, 4'hF, 32'h12345678, 32'h0, 1'b1, 3});
    tbl.push_back('{1, 2, 32'h0, 4'h0, 32'h0, 32'hCAFEF00D, 1'b0, 3});
    tbl.push_back('{1, 0, 32'h0, 4'hC, 32'h99880000, 32'h0, 1'b0, 3});
    tbl.push_back('{1, 1, 32'h0, 4'h0, 32'h0, 32'h9988F00D, 1'b0, 3});
    foreach (tbl[i]) begin
      xact(tbl[i].u, tbl[i].p, tbl[i].a, tbl[i].s, tbl[i].d, rd, e, lat, gok);
      check($sformatf("vec%0d_grant", i), 32'(gok), 32'd1);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(tbl[i].el));
      check($sformatf("vec%0d_rdata", i), rd, tbl[i].er);
      check($sformatf("vec%0d_err", i), 32'(e), 32'(tbl[i].ee));
    end
    gseq(0, '{0, 1, 2, 0, 1, 2, 0, 1});
    gseq(1, '{0, 1, 2, -1, 0, 1, 2, -1});
    do_reset();
    addr[1] = {32'h0, 32'h4, 32'h0};
    strb[1] = '0;
    valid[1] = 3'b001;
    @(negedge clk);
    check("abort_grant", {28'd0, gv[1], gid[1]}, 32'h8);
    @(posedge clk); #1;
    resetn = 0;
    valid[1] = 3'b011;
    @(negedge clk);
    check("abort_nogrant", 32'(gv[1]), 32'd0);
    @(posedge clk); #1;
    resetn = 1;
    valid[1] = '0;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      n += int'(|ready[1]);
    end
    check("abort_noready", 32'(n), 32'd0);
    @(posedge clk); #1;
    xact(1, 0, 32'h0, 4'h0, 32'h0, rd, e, lat, gok);
    check("abort_next_lat", 32'(lat), 32'd3);
    check("abort_next_rdata", rd, 32'h9988F00D);
    rand_run(0, 1, 1, 300);
    rand_run(1, 3, 0, 300);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
